// File: rtl/sync_fifo_stream_reader.sv
// Read-side drain engine for Sync_fifo: pops words over rd_en/empty/dout and re-presents them as a
// valid/ready stream through a 2-entry buffer. Define SYNC_FIFO_RD_CNT_EN to add the rd_word_cnt port.
module sync_fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
`ifdef SYNC_FIFO_RD_CNT_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef SYNC_FIFO_RD_CNT_EN
    , output logic [CNT_WIDTH-1:0] rd_word_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    buf_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  inflight_q;
    logic                  capture;
    logic                  pop;
    logic [1:0]            occupancy;

    assign capture   = inflight_q;
    assign pop       = (state_q != EMPTY) & m_ready;
    // Encoding equals buffered word count, so occupancy covers words held plus the one on its way.
    assign occupancy = 2'(state_q) + {1'b0, inflight_q};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_comb begin
        // NOTE: defaulting every target to its held value first keeps this block free of inferred latches.
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (capture) begin
                    state_d = ONE;
                    head_d  = fifo_dout;
                end
            end
            ONE: begin
                if (capture && !pop) begin
                    state_d = TWO;
                    tail_d  = fifo_dout;
                end else if (capture && pop) begin
                    head_d  = fifo_dout;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        m_valid    = (state_q != EMPTY);
        m_data     = head_q;
        // Top up only while the buffer has room, counting a pop this cycle as freed space.
        fifo_rd_en = !rst && !fifo_empty &&
                     ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((state_q == TWO) && capture));
        end
    end

`ifdef SYNC_FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign rd_word_cnt = cnt_q;
`endif

endmodule
